filter_result_fifo: RTL and testbench

Buffers results from the `filter` block so a slower consumer (PCAP/readback path) can drain them without losing samples. It captures `out_o` on each `ready_o` pulse into a first-word-fall-through FIFO and presents entries on a valid/ready stream. It also latches the filter's error flags, tracks overflow and counts dropped results. Sits directly downstream of `filter`, on the same clock.

---
 rtl/filter_result_fifo.sv | 95 +++++++++
 tb/tb_filter_result_fifo.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/filter_result_fifo.sv
// First-word-fall-through buffer between the filter result strobe and a slower
// valid/ready consumer, with sticky error/overflow flags and a drop counter.
module filter_result_fifo #(
    parameter int DEPTH = 16,
    parameter int DW    = 32
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     enable_i,
    input  logic [DW-1:0]            res_i,
    input  logic                     res_valid_i,
    input  logic [1:0]               ferr_i,
    output logic [DW-1:0]            data_o,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic [15:0]              dropped_o,
    output logic [2:0]               health_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [CW-1:0] count;
    logic [15:0]   dropped;
    logic [2:0]    health;
    logic          en_d;

    logic flush, push, pop, full, wr, drop;

    assign flush = enable_i & ~en_d;
    // The push is masked in the flush cycle so a result arriving with the
    // enable edge can never survive the clear.
    assign push  = res_valid_i & enable_i & en_d;
    assign pop   = (count != '0) & ready_i;
    assign full  = (count == FULL_COUNT);
    assign wr    = push & (~full | pop);
    assign drop  = push & full & ~pop;

    // NOTE: the storage array has no reset; contents are only observable through
    // data_o, which is forced to zero while the FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (wr)
            mem[wp] <= res_i;
    end

    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            en_d    <= 1'b0;
            wp      <= '0;
            rp      <= '0;
            count   <= '0;
            dropped <= '0;
            health  <= '0;
        end else begin
            en_d <= enable_i;
            if (flush) begin
                wp      <= '0;
                rp      <= '0;
                count   <= '0;
                dropped <= '0;
                health  <= '0;
            end else begin
                if (wr)
                    wp <= wp + AW'(1);
                if (pop)
                    rp <= rp + AW'(1);
                case ({wr, pop})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
                if (drop) begin
                    health[2] <= 1'b1;
                    if (dropped != 16'hFFFF)
                        dropped <= dropped + 16'd1;
                end
                if (enable_i)
                    health[1:0] <= health[1:0] | ferr_i;
            end
        end
    end

    assign valid_o   = (count != '0);
    assign data_o    = valid_o ? mem[rp] : '0;
    assign count_o   = count;
    assign dropped_o = dropped;
    assign health_o  = health;

endmodule

// File: tb/tb_filter_result_fifo.sv
// Directed bench for filter_result_fifo: a per-cycle vector table followed by
// hand-written overflow, disable-drain and asynchronous-reset sequences.
module tb_filter_result_fifo;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic [31:0] res = '0;
    logic        res_valid = 1'b0;
    logic [1:0]  ferr = '0;
    logic        ready = 1'b0;
    logic [31:0] data;
    logic        valid;
    logic [4:0]  count;
    logic [15:0] dropped;
    logic [2:0]  health;

    int n_checks = 0;
    int n_errors = 0;

    filter_result_fifo #(.DEPTH(16), .DW(32)) dut (
        .clk_i      (clk),
        .reset_n_i  (reset_n),
        .enable_i   (enable),
        .res_i      (res),
        .res_valid_i(res_valid),
        .ferr_i     (ferr),
        .data_o     (data),
        .valid_o    (valid),
        .ready_i    (ready),
        .count_o    (count),
        .dropped_o  (dropped),
        .health_o   (health)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic        rv;
        logic [31:0] res;
        logic [1:0]  ferr;
        logic        rdy;
        logic        exp_valid;
        logic [31:0] exp_data;
        logic [4:0]  exp_count;
        logic [15:0] exp_dropped;
        logic [2:0]  exp_health;
    } vec_t;

    vec_t vecs [18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drive inputs, take one rising edge, then settle 1 time unit past it.
    task automatic step(input logic en, input logic rv, input logic [31:0] r,
                        input logic [1:0] fe, input logic rdy);
        enable    = en;
        res_valid = rv;
        res       = r;
        ferr      = fe;
        ready     = rdy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        //          en rv res ferr rdy  val data cnt drop hlth
        vecs[0]  = '{1, 0,  0, 0, 0,   0,  0, 0, 0, 0};  // flush on first enable
        vecs[1]  = '{1, 1, 10, 0, 0,   1, 10, 1, 0, 0};
        vecs[2]  = '{1, 0,  0, 0, 0,   1, 10, 1, 0, 0};
        vecs[3]  = '{1, 1, 20, 0, 0,   1, 10, 2, 0, 0};
        vecs[4]  = '{1, 0,  0, 0, 0,   1, 10, 2, 0, 0};
        vecs[5]  = '{1, 1, 30, 0, 0,   1, 10, 3, 0, 0};
        vecs[6]  = '{1, 0,  0, 0, 1,   1, 20, 2, 0, 0};
        vecs[7]  = '{1, 0,  0, 0, 1,   1, 30, 1, 0, 0};
        vecs[8]  = '{1, 0,  0, 0, 1,   0,  0, 0, 0, 0};
        vecs[9]  = '{1, 0,  0, 1, 0,   0,  0, 0, 0, 1};
        vecs[10] = '{1, 0,  0, 2, 0,   0,  0, 0, 0, 3};
        vecs[11] = '{1, 0,  0, 0, 0,   0,  0, 0, 0, 3};
        vecs[12] = '{0, 1,  5, 0, 0,   0,  0, 0, 0, 3};  // disabled push ignored
        vecs[13] = '{1, 1, 77, 0, 0,   0,  0, 0, 0, 0};  // flush drops this push
        vecs[14] = '{1, 1, 88, 0, 0,   1, 88, 1, 0, 0};
        vecs[15] = '{1, 0,  0, 0, 1,   0,  0, 0, 0, 0};
        vecs[16] = '{0, 0,  0, 3, 0,   0,  0, 0, 0, 0};  // errors ignored while disabled
        vecs[17] = '{1, 0,  0, 0, 0,   0,  0, 0, 0, 0};

        // Reset values while reset is held
        #1;
        check("reset valid", 32'(valid), 32'd0);
        check("reset data", data, 32'd0);
        check("reset count", 32'(count), 32'd0);
        check("reset dropped", 32'(dropped), 32'd0);
        check("reset health", 32'(health), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 18; i++) begin
            step(vecs[i].en, vecs[i].rv, vecs[i].res, vecs[i].ferr, vecs[i].rdy);
            check($sformatf("row%0d valid", i), 32'(valid), 32'(vecs[i].exp_valid));
            check($sformatf("row%0d data", i), data, vecs[i].exp_data);
            check($sformatf("row%0d count", i), 32'(count), 32'(vecs[i].exp_count));
            check($sformatf("row%0d dropped", i), 32'(dropped), 32'(vecs[i].exp_dropped));
            check($sformatf("row%0d health", i), 32'(health), 32'(vecs[i].exp_health));
        end

        // Overflow: 20 pushes into a 16-deep FIFO with no consumer
        for (int i = 1; i <= 20; i++) begin
            step(1, 1, 32'(i), 0, 0);
            if (i == 16) begin
                check("ovf count at 16", 32'(count), 32'd16);
                check("ovf dropped at 16", 32'(dropped), 32'd0);
                check("ovf health at 16", 32'(health), 32'd0);
            end
        end
        check("ovf count", 32'(count), 32'd16);
        check("ovf dropped", 32'(dropped), 32'd4);
        check("ovf health", 32'(health), 32'd4);
        check("ovf head", data, 32'd1);

        // Full boundary: push and pop together while full
        step(1, 1, 32'd99, 0, 1);
        check("full pushpop count", 32'(count), 32'd16);
        check("full pushpop dropped", 32'(dropped), 32'd4);
        check("full pushpop head", data, 32'd2);

        for (int k = 0; k < 16; k++) begin
            check($sformatf("drain%0d valid", k), 32'(valid), 32'd1);
            check($sformatf("drain%0d data", k), data, (k < 15) ? 32'(k + 2) : 32'd99);
            step(1, 0, 0, 0, 1);
        end
        check("drain end valid", 32'(valid), 32'd0);
        check("drain end count", 32'(count), 32'd0);
        check("drain end dropped held", 32'(dropped), 32'd4);
        check("drain end health held", 32'(health), 32'd4);

        // Disable drain: 5 stored, 3 pushed while disabled, exactly 5 read
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        check("flush2 dropped", 32'(dropped), 32'd0);
        check("flush2 health", 32'(health), 32'd0);
        for (int i = 0; i < 5; i++) step(1, 1, 32'(100 + i), 0, 0);
        check("dd fill count", 32'(count), 32'd5);
        for (int i = 0; i < 3; i++) step(0, 1, 32'(200 + i), 0, 0);
        check("dd disabled push count", 32'(count), 32'd5);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("dd%0d valid", k), 32'(valid), 32'd1);
            check($sformatf("dd%0d data", k), data, 32'(100 + k));
            step(0, 0, 0, 0, 1);
        end
        check("dd end valid", 32'(valid), 32'd0);
        step(0, 0, 0, 0, 1);
        check("dd idle count", 32'(count), 32'd0);

        // Asynchronous reset with 7 entries buffered
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) step(1, 1, 32'(300 + i), (i == 0) ? 2'b01 : 2'b00, 0);
        check("ar pre count", 32'(count), 32'd7);
        check("ar pre health", 32'(health), 32'd1);
        res_valid = 1'b0;
        #3;
        reset_n = 1'b0;
        #1;
        check("ar count", 32'(count), 32'd0);
        check("ar valid", 32'(valid), 32'd0);
        check("ar health", 32'(health), 32'd0);
        check("ar data", data, 32'd0);
        @(posedge clk);
        #1;
        check("ar held count", 32'(count), 32'd0);
        reset_n = 1'b1;
        step(0, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
